// File: rtl/fir_mac_core.sv
`default_nettype none
// ============================================================================
// Module   : fir_mac_core
// Purpose  : Serial multiply-accumulate FIR datapath. Holds an NTAPS-deep
//            sample delay line and coefficient file, and computes one filter
//            output per accepted sample on a single shared multiplier. The
//            accumulator is scaled by an arithmetic right shift and saturated
//            to DATA_W bits.
// Ports    : s00_axi_aclk / s00_axi_aresetn  clock, async active-low reset
//            in_valid / in_data / in_ready    sample handshake
//            coef_we / coef_addr / coef_data  coefficient write (IDLE only)
//            clr_hist                         delay-line clear (IDLE only)
//            busy                             core is not IDLE
//            out_valid / out_data / out_sat   result (held until out_ready)
//            out_ready                        result consumed
// Revision : 1.0  initial release
// ============================================================================
module fir_mac_core #(
    parameter  int NTAPS     = 8,
    parameter  int DATA_W    = 16,
    parameter  int COEF_W    = 16,
    parameter  int OUT_SHIFT = 15,
    localparam int ACC_W     = DATA_W + COEF_W + $clog2(NTAPS),
    localparam int CNT_W     = $clog2(NTAPS)
) (
    input  logic                     s00_axi_aclk,
    input  logic                     s00_axi_aresetn,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     in_ready,
    input  logic                     coef_we,
    input  logic        [CNT_W-1:0]  coef_addr,
    input  logic signed [COEF_W-1:0] coef_data,
    input  logic                     clr_hist,
    output logic                     busy,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     out_sat,
    input  logic                     out_ready
);

    localparam int              c_prod_w   = DATA_W + COEF_W;
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(NTAPS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic signed [DATA_W-1:0] r_x [NTAPS];
    logic signed [COEF_W-1:0] r_h [NTAPS];
    logic signed [ACC_W-1:0]  r_acc;
    logic        [CNT_W-1:0]  r_cnt;
    logic                     r_in_ready;
    logic                     r_out_valid;
    logic signed [DATA_W-1:0] r_out_data;
    logic                     r_out_sat;

    logic                     w_accept;
    logic                     w_last;
    logic signed [c_prod_w-1:0] w_prod;
    logic signed [ACC_W-1:0]  w_acc_next;
    logic signed [ACC_W-1:0]  w_acc_shift;
    logic [ACC_W-DATA_W:0]    w_acc_hi;
    logic                     w_ovf;
    logic signed [DATA_W-1:0] w_sat_data;

    assign w_accept = (r_state == ST_IDLE) && in_valid && r_in_ready;
    assign w_last   = (r_state == ST_MAC) && (r_cnt == c_cnt_last);

    // Full-precision product, sign-extended into the accumulator. ACC_W has
    // log2(NTAPS) guard bits so the running sum cannot wrap.
    assign w_prod      = r_x[r_cnt] * r_h[r_cnt];
    assign w_acc_next  = r_acc + {{(ACC_W - c_prod_w){w_prod[c_prod_w-1]}}, w_prod};
    assign w_acc_shift = w_acc_next >>> OUT_SHIFT;

    // The shifted value fits in DATA_W bits only if every bit from the
    // output sign position upward is a copy of the sign.
    assign w_acc_hi   = w_acc_shift[ACC_W-1:DATA_W-1];
    assign w_ovf      = !((&w_acc_hi) || (~|w_acc_hi));
    assign w_sat_data = !w_ovf ? w_acc_shift[DATA_W-1:0]
                      : w_acc_shift[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                      :                        {1'b0, {(DATA_W-1){1'b1}}};

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)  w_state_next = ST_MAC;
            ST_MAC:  if (w_last)    w_state_next = ST_DONE;
            ST_DONE: if (out_ready) w_state_next = ST_IDLE;
            default:                w_state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            for (int k = 0; k < NTAPS; k++) begin
                r_x[k] <= '0;
                r_h[k] <= '0;
            end
            r_acc       <= '0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sat   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // in_ready is low in IDLE only on the first edge after
                    // reset release; otherwise it drops only on an accept.
                    r_in_ready <= !w_accept;
                    // Written here so a same-edge accept sees the new value
                    // on its first MAC cycle.
                    if (coef_we) begin
                        r_h[coef_addr] <= coef_data;
                    end
                    if (w_accept) begin
                        for (int k = 1; k < NTAPS; k++) begin
                            r_x[k] <= clr_hist ? '0 : r_x[k-1];
                        end
                        r_x[0] <= in_data;
                        r_acc  <= '0;
                        r_cnt  <= '0;
                    end else if (clr_hist) begin
                        for (int k = 0; k < NTAPS; k++) begin
                            r_x[k] <= '0;
                        end
                    end
                end
                ST_MAC: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_out_data  <= w_sat_data;
                        r_out_sat   <= w_ovf;
                        r_out_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_out_sat   <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign busy      = (r_state != ST_IDLE);
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sat   = r_out_sat;

endmodule
`default_nettype wire
